// File: rtl/time_keeper_if.sv
// -----------------------------------------------------------------------------
// time_keeper_if
// Bundles the button inputs and time/status outputs of the time_keeper clock.
//
// Signals
//   mode_btn  1  one-cycle pulse, advances RUN -> SET_HR -> SET_MIN -> RUN
//   up_btn    1  one-cycle pulse, increments the field selected in a SET mode
//   sec       6  seconds 0..59
//   min       6  minutes 0..59
//   hr        5  hours 0..23
//   mode      2  00 RUN, 01 SET_HR, 10 SET_MIN
//   sec_tick  1  one-cycle pulse in the cycle after each 1 s update
//   day_wrap  1  one-cycle pulse in the cycle after hr wraps 23 -> 0
//
// Modports
//   master  drives the buttons, observes the time (user / host side)
//   slave   the clock core itself
// -----------------------------------------------------------------------------
interface time_keeper_if;
  logic       mode_btn;
  logic       up_btn;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic [1:0] mode;
  logic       sec_tick;
  logic       day_wrap;

  modport master (
    output mode_btn,
    output up_btn,
    input  sec,
    input  min,
    input  hr,
    input  mode,
    input  sec_tick,
    input  day_wrap
  );

  modport slave (
    input  mode_btn,
    input  up_btn,
    output sec,
    output min,
    output hr,
    output mode,
    output sec_tick,
    output day_wrap
  );
endinterface

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// 24-hour time-of-day clock with a 1 s prescaler and a three-state setting FSM.
// In RUN the prescaler divides clk by TICK_DIV and each tick advances
// sec/min/hr with carries applied on one edge. In SET_HR / SET_MIN the
// prescaler is parked at 0 and up_btn steps the selected field without carry.
// Leaving SET_MIN clears sec and the prescaler so the next second is full.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of time_keeper_if (buttons in, time/status out)
//
// Parameters
//   TICK_DIV  clock cycles per 1 s tick, >= 2
//
// FSM states
//   state   | meaning
//   RUN     | time advances on prescaler ticks, up_btn ignored
//   SET_HR  | clock frozen, up_btn steps hr 0..23 (wraps, no carry)
//   SET_MIN | clock frozen, up_btn steps min 0..59 (wraps, no carry)
// -----------------------------------------------------------------------------
module time_keeper #(
  parameter int TICK_DIV = 50000000
) (
  input  logic          clk,
  input  logic          reset,
  time_keeper_if.slave  bus
);

  localparam int             CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TC = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [CW-1:0]  presc;
  logic [5:0]     sec_q;
  logic [5:0]     min_q;
  logic [4:0]     hr_q;
  logic           sec_tick_q;
  logic           day_wrap_q;

  // decoded actions for the current cycle
  logic           tick;
  logic           hr_step;
  logic           min_step;
  logic           run_entry;

  logic           sec_last;
  logic           min_last;
  logic           hr_last;

  assign sec_last = (sec_q == 6'd59);
  assign min_last = (min_q == 6'd59);
  assign hr_last  = (hr_q  == 5'd23);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (bus.mode_btn) state_next = SET_HR;
      SET_HR:  if (bus.mode_btn) state_next = SET_MIN;
      SET_MIN: if (bus.mode_btn) state_next = RUN;
      default: state_next = RUN;  // unused encoding recovers to RUN
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / action decode
  // mode_btn wins over up_btn, so the step enables are masked by it.
  // ---------------------------------------------------------------------------
  always_comb begin
    tick      = 1'b0;
    hr_step   = 1'b0;
    min_step  = 1'b0;
    run_entry = 1'b0;
    case (state)
      RUN: begin
        tick = (presc == TC);
      end
      SET_HR: begin
        hr_step = bus.up_btn & ~bus.mode_btn;
      end
      SET_MIN: begin
        min_step  = bus.up_btn & ~bus.mode_btn;
        run_entry = bus.mode_btn;
      end
      default: begin
        tick = 1'b0;
      end
    endcase
  end

  assign bus.mode = state;

  // ---------------------------------------------------------------------------
  // Prescaler: counts only in RUN, parked at 0 otherwise. Because SET_MIN
  // already holds it at 0, the SET_MIN -> RUN edge leaves it cleared and the
  // first tick lands TICK_DIV cycles later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (state != RUN) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Time fields. tick only occurs in RUN and the step / run_entry actions only
  // in SET states, so the branches below are mutually exclusive. The carry
  // chain is resolved combinationally from the current values, so all fields
  // move on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q <= 6'd0;
      min_q <= 6'd0;
      hr_q  <= 5'd0;
    end else if (tick) begin
      if (!sec_last) begin
        sec_q <= sec_q + 6'd1;
      end else begin
        sec_q <= 6'd0;
        if (!min_last) begin
          min_q <= min_q + 6'd1;
        end else begin
          min_q <= 6'd0;
          hr_q  <= hr_last ? 5'd0 : hr_q + 5'd1;
        end
      end
    end else if (run_entry) begin
      sec_q <= 6'd0;
    end else if (hr_step) begin
      hr_q <= hr_last ? 5'd0 : hr_q + 5'd1;
    end else if (min_step) begin
      min_q <= min_last ? 6'd0 : min_q + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status pulses, registered alongside the fields they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      sec_tick_q <= tick;
      day_wrap_q <= tick & sec_last & min_last & hr_last;
    end
  end

  assign bus.sec      = sec_q;
  assign bus.min      = min_q;
  assign bus.hr       = hr_q;
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_keeper_if bus ();

  time_keeper #(.TICK_DIV(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int n_tick = 0;
  int n_wrap = 0;

  // reference model: time of day as seconds since midnight
  int m_tod   = 0;
  int m_phase = 0;
  int m_mode  = 0;
  bit m_tick  = 0;
  bit m_wrap  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit mb, input bit ub);
    int h, m;
    if (r) begin
      m_tod = 0; m_phase = 0; m_mode = 0; m_tick = 0; m_wrap = 0;
    end else begin
      m_tick = (m_mode == 0) && (m_phase == TD - 1);
      m_wrap = m_tick && (m_tod == 86399);
      if (m_tick) m_tod = (m_tod + 1) % 86400;
      m_phase = (m_mode == 0) ? (m_phase + 1) % TD : 0;
      if (mb) begin
        if (m_mode == 2) begin
          m_tod   = m_tod - (m_tod % 60);
          m_phase = 0;
        end
        m_mode = (m_mode + 1) % 3;
      end else if (ub && m_mode == 1) begin
        h = m_tod / 3600;
        m_tod = ((h + 1) % 24) * 3600 + (m_tod % 3600);
      end else if (ub && m_mode == 2) begin
        m = (m_tod / 60) % 60;
        m_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
      end
    end
  endtask

  // one clock: drive, edge, update model, sample #1 later, compare with model
  task automatic cyc(input bit r, input bit mb, input bit ub);
    reset = r; bus.mode_btn = mb; bus.up_btn = ub;
    @(posedge clk);
    model_step(r, mb, ub);
    cyc_n++;
    #1;
    if (bus.sec_tick) n_tick++;
    if (bus.day_wrap) n_wrap++;
    chk("sec",      int'(bus.sec),      m_tod % 60);
    chk("min",      int'(bus.min),      (m_tod / 60) % 60);
    chk("hr",       int'(bus.hr),       m_tod / 3600);
    chk("mode",     int'(bus.mode),     m_mode);
    chk("sec_tick", int'(bus.sec_tick), int'(m_tick));
    chk("day_wrap", int'(bus.day_wrap), int'(m_wrap));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  typedef struct {
    bit r, mb, ub;
    int sec, min, hr, mode;
    bit tk, wr;
  } vec_t;

  vec_t tbl [19];

  initial begin
    reset = 1'b1; bus.mode_btn = 1'b0; bus.up_btn = 1'b0;

    //             r  mb ub sec min hr mode tk wr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 1, 0};  // first tick TD cycles after reset edge
    tbl[5]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0};  // up ignored in RUN
    tbl[6]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 1, 1, 0, 0};
    tbl[8]  = '{0, 0, 1, 1, 0, 2, 1, 0, 0};
    tbl[9]  = '{0, 1, 1, 1, 0, 2, 2, 0, 0};  // mode wins over up
    tbl[10] = '{0, 0, 1, 1, 1, 2, 2, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 2, 2, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 1, 2, 0, 0, 0};  // back to RUN clears sec
    tbl[13] = '{0, 0, 0, 0, 1, 2, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 1, 2, 0, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 1, 2, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 1, 2, 0, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 1, 2, 0, 0, 0};
    tbl[18] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};  // reset beats buttons

    @(negedge clk);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].r, tbl[i].mb, tbl[i].ub);
      chk("tbl_sec",  int'(bus.sec),      tbl[i].sec);
      chk("tbl_min",  int'(bus.min),      tbl[i].min);
      chk("tbl_hr",   int'(bus.hr),       tbl[i].hr);
      chk("tbl_mode", int'(bus.mode),     tbl[i].mode);
      chk("tbl_tick", int'(bus.sec_tick), int'(tbl[i].tk));
      chk("tbl_wrap", int'(bus.day_wrap), int'(tbl[i].wr));
    end

    // ---------------- 240 cycles of RUN ----------------
    cyc(1, 0, 0);
    n_tick = 0;
    idle(240);
    chk("run240_ticks", n_tick, 60);
    chk("run240_sec", int'(bus.sec), 0);
    chk("run240_min", int'(bus.min), 1);
    chk("run240_hr",  int'(bus.hr),  0);

    // ---------------- 23:59 rolls over to midnight ----------------
    cyc(1, 0, 0);
    cyc(0, 1, 0); ups(23);
    cyc(0, 1, 0); ups(59);
    cyc(0, 1, 0);
    chk("set_2359_hr",  int'(bus.hr),  23);
    chk("set_2359_min", int'(bus.min), 59);
    n_wrap = 0;
    idle(240);
    chk("midnight_hr",   int'(bus.hr),  0);
    chk("midnight_min",  int'(bus.min), 0);
    chk("midnight_sec",  int'(bus.sec), 0);
    chk("midnight_wrap_count", n_wrap, 1);

    // ---------------- hr wraps in SET_HR without side effects ----------------
    cyc(1, 0, 0);
    cyc(0, 1, 0); ups(5);
    n_wrap = 0; n_tick = 0;
    ups(24);
    chk("sethr24_hr",   int'(bus.hr),  5);
    chk("sethr24_min",  int'(bus.min), 0);
    chk("sethr24_wrap", n_wrap, 0);
    chk("sethr24_tick", n_tick, 0);

    // ---------------- mode and up together in SET_HR ----------------
    cyc(1, 0, 0);
    cyc(0, 1, 0); ups(3);
    cyc(0, 1, 1);
    chk("both_mode", int'(bus.mode), 2);
    chk("both_hr",   int'(bus.hr),   3);

    // ---------------- reset with up in SET_MIN ----------------
    ups(12);
    chk("setmin_min", int'(bus.min), 12);
    cyc(1, 0, 1);
    chk("rst_sec",  int'(bus.sec),  0);
    chk("rst_min",  int'(bus.min),  0);
    chk("rst_hr",   int'(bus.hr),   0);
    chk("rst_mode", int'(bus.mode), 0);

    // ---------------- up ignored in RUN between ticks ----------------
    idle(28);
    chk("run_sec7", int'(bus.sec), 7);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1);
      chk("runup_sec", int'(bus.sec), 7);
      chk("runup_min", int'(bus.min), 0);
      chk("runup_hr",  int'(bus.hr),  0);
    end
    cyc(0, 0, 1);
    chk("runup_next_tick", int'(bus.sec), 8);

    // ---------------- randomized against the model ----------------
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 599) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clock cycles per 1 s tick; legal range 2 and above.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mode_btn  input  1  one-cycle pulse (pre-debounced); advances the mode FSM.
REQ-005 up_btn  input  1  one-cycle pulse (pre-debounced); increments the field selected in a SET mode.
REQ-006 sec  output  6  seconds, 0..59, registered.
REQ-007 min  output  6  minutes, 0..59, registered.
REQ-008 hr  output  5  hours, 0..23, registered.
REQ-009 mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 is never driven.
REQ-010 sec_tick  output  1  one-cycle pulse, high in the cycle after each 1 s update of sec.
REQ-011 day_wrap  output  1  one-cycle pulse, high in the cycle after hr wraps from 23 to 0 on a tick.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 in RUN; the internal tick SHALL fire on the cycle the count equals TICK_DIV-1, and the count SHALL then wrap to 0.
REQ-013 In SET_HR and SET_MIN, the prescaler SHALL be held at 0 and no ticks SHALL fire.
REQ-014 On a tick: sec<59 -> sec+1; sec==59 -> sec=0 with a carry into min.
REQ-015 On a carry into min: min<59 -> min+1; min==59 -> min=0 with a carry into hr.
REQ-016 On a carry into hr: hr<23 -> hr+1; hr==23 -> hr=0, and day_wrap SHALL pulse.
REQ-017 All three fields SHALL update on the same clock edge for a multi-field carry; no intermediate value SHALL be visible.
REQ-018 Increment arithmetic SHALL be 6-bit for sec and min and 5-bit for hr; comparisons SHALL be against 59 and 23 respectively.
REQ-019 FSM transitions on mode_btn SHALL be RUN->SET_HR->SET_MIN->RUN; otherwise the FSM SHALL hold its state.
REQ-020 In SET_HR, up_btn SHALL step hr as 23->0 and otherwise hr+1, with no effect on min or sec.
REQ-021 In SET_MIN, up_btn SHALL step min as 59->0 and otherwise min+1, with no carry into hr.
REQ-022 In SET states, up_btn SHALL NOT pulse day_wrap or sec_tick.
REQ-023 In RUN, up_btn SHALL be ignored.
REQ-024 When mode_btn and up_btn are high in the same cycle, mode_btn SHALL take effect and up_btn SHALL be ignored.
REQ-025 On the SET_MIN->RUN transition, sec and the prescaler SHALL be cleared to 0, so the first tick occurs TICK_DIV cycles after the transition edge.
REQ-026 The mode output SHALL reflect the FSM state register directly, with no extra latency.
REQ-027 The pulse outputs SHALL be registered, and each pulse SHALL last exactly one cycle.

Reset
REQ-028 When reset is high at a clock edge, the following SHALL hold after that edge regardless of other inputs: sec=0, min=0, hr=0, mode=RUN, prescaler=0, sec_tick=0, day_wrap=0.
REQ-029 Reset SHALL take priority over mode_btn, up_btn and any pending tick in the same cycle.
REQ-030 Counting SHALL resume in RUN, with the first tick TICK_DIV cycles after the first edge with reset low.

Verification
REQ-031 TICK_DIV=4; reset, then run 240 cycles -> sec_tick pulses every 4 cycles; after the 60th tick sec=0, min=1, hr=0.
REQ-032 TICK_DIV=4; set hr=23 (23 up pulses in SET_HR) and min=59 (59 up pulses in SET_MIN); return to RUN; apply 60 ticks -> hr=0, min=0, sec=0, and day_wrap high for exactly 1 cycle.
REQ-033 SET_HR with hr=5; 24 up pulses -> hr=5, min unchanged, day_wrap never asserted.
REQ-034 In SET_HR with hr=3, mode_btn and up_btn asserted in the same cycle -> mode=10, hr=3.
REQ-035 In SET_MIN with min=12, reset and up_btn asserted together -> next cycle sec=0, min=0, hr=0, mode=00.
REQ-036 In RUN with sec=7, up_btn pulses between ticks -> sec, min and hr unchanged until the next tick.
